// File: rtl/hanoi_move_checker.sv
// Tower of Hanoi move checker: tracks the peg that holds each disk, checks each incoming
// move for legality, applies the legal ones, and halts on the first illegal move.
module hanoi_move_checker #(
  parameter int NUM_DISKS  = 3,
  parameter int START_PEG  = 0,
  parameter int TARGET_PEG = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 move_valid,
  input  logic [1:0]           frompeg,
  input  logic [1:0]           topeg,
  output logic                 move_ready,
  output logic                 move_ack,
  output logic                 illegal,
  output logic [1:0]           err_code,
  output logic [2:0]           disk_moved,
  output logic [7:0]           move_count,
  output logic                 done,
  output logic [NUM_DISKS-1:0] peg0_mask,
  output logic [NUM_DISKS-1:0] peg1_mask,
  output logic [NUM_DISKS-1:0] peg2_mask
);

  localparam logic [1:0] START  = START_PEG[1:0];
  localparam logic [1:0] TARGET = TARGET_PEG[1:0];

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, HALT} state_t;

  state_t     state;
  logic [1:0] loc [NUM_DISKS];
  logic [1:0] cap_from;
  logic [1:0] cap_to;
  logic       src_found;
  logic       dst_found;
  logic [2:0] src_top;
  logic [2:0] dst_top;
  logic [1:0] chk_err;

  always_comb begin
    peg0_mask = '0;
    peg1_mask = '0;
    peg2_mask = '0;
    done      = 1'b1;
    for (int unsigned i = 0; i < NUM_DISKS; i++) begin
      peg0_mask[i] = (loc[i] == 2'd0);
      peg1_mask[i] = (loc[i] == 2'd1);
      peg2_mask[i] = (loc[i] == 2'd2);
      if (loc[i] != TARGET) done = 1'b0;
    end
  end

  // Top of a peg is the lowest-indexed disk on it; peg code 3 never matches any disk.
  always_comb begin
    src_found = 1'b0;
    dst_found = 1'b0;
    src_top   = '0;
    dst_top   = '0;
    for (int unsigned i = 0; i < NUM_DISKS; i++) begin
      if (!src_found && loc[i] == cap_from) begin
        src_found = 1'b1;
        src_top   = 3'(i);
      end
      if (!dst_found && loc[i] == cap_to) begin
        dst_found = 1'b1;
        dst_top   = 3'(i);
      end
    end
  end

  always_comb begin
    chk_err = 2'd0;
    if (cap_from == 2'd3 || cap_to == 2'd3 || cap_from == cap_to)
      chk_err = 2'd1;
    else if (!src_found)
      chk_err = 2'd2;
    else if (dst_found && dst_top < src_top)
      chk_err = 2'd3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cap_from   <= '0;
      cap_to     <= '0;
      move_ready <= 1'b1;
      move_ack   <= 1'b0;
      illegal    <= 1'b0;
      err_code   <= '0;
      disk_moved <= '0;
      move_count <= '0;
      for (int unsigned i = 0; i < NUM_DISKS; i++) loc[i] <= START;
    end else begin
      move_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid && move_ready) begin
            cap_from   <= frompeg;
            cap_to     <= topeg;
            move_ready <= 1'b0;
            state      <= CHECK;
          end
        end
        // The move is committed on leaving CHECK so that the ack and the updated
        // peg state appear together during APPLY.
        CHECK: begin
          if (chk_err == 2'd0) begin
            for (int unsigned i = 0; i < NUM_DISKS; i++)
              if (3'(i) == src_top) loc[i] <= cap_to;
            disk_moved <= src_top;
            if (move_count != 8'hFF) move_count <= move_count + 8'd1;
            move_ack   <= 1'b1;
            state      <= APPLY;
          end else begin
            illegal  <= 1'b1;
            err_code <= chk_err;
            state    <= HALT;
          end
        end
        APPLY: begin
          move_ready <= 1'b1;
          state      <= IDLE;
        end
        HALT: begin
          move_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
